// File: rtl/uart_dbg_loader.sv
// UART debug download responder: collects 35-byte indexed, CRC16-Modbus protected packets,
// writes their payload words to instruction memory and answers every packet with ACK or NACK.
module uart_dbg_loader #(
   parameter int unsigned CLKS_PER_BIT = 8,
   parameter logic [31:0] BASE_ADDR    = 32'h0,
   parameter int unsigned GAP_TIMEOUT  = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        dbg_en,
   input  logic        uart_rx_pin,
   output logic        uart_tx_pin,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        cpu_hold,
   output logic        dl_done,
   output logic [31:0] file_size
);
   localparam int unsigned CW   = $clog2(CLKS_PER_BIT + 1);
   localparam int unsigned GW   = $clog2(GAP_TIMEOUT + 1);
   localparam logic [7:0]  ACK  = 8'h06;
   localparam logic [7:0]  NACK = 8'h15;

   typedef enum logic [1:0] {S_IDLE, S_RECV, S_CHECK, S_WRITE} state_t;

   function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
      logic [15:0] c;
      c = crc ^ {8'h00, data};
      for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
      return c;
   endfunction

   logic          rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_s3_q, rx_s3_d;
   logic          rx_busy_q, rx_busy_d, rx_valid_q, rx_valid_d, rx_ferr_q, rx_ferr_d;
   logic [CW-1:0] rx_cnt_q, rx_cnt_d;
   logic [3:0]    rx_bit_q, rx_bit_d;
   logic [7:0]    rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;

   state_t        state_q, state_d;
   logic [5:0]    byte_cnt_q, byte_cnt_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [15:0]   crc_q, crc_d;
   logic [7:0]    exp_idx_q, exp_idx_d;
   logic [2:0]    word_q, word_d;

   logic          tx_busy_q, tx_busy_d, tx_pin_q, tx_pin_d;
   logic [CW-1:0] tx_cnt_q, tx_cnt_d;
   logic [3:0]    tx_left_q, tx_left_d;
   logic [8:0]    tx_frame_q, tx_frame_d;

   logic          mem_we_q, mem_we_d, dl_done_q, dl_done_d;
   logic [31:0]   mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d, file_size_q, file_size_d;

   logic [7:0]    pkt_mem [0:34];
   logic          buf_we, tx_start;
   logic [5:0]    buf_idx, wbase;
   logic [7:0]    tx_byte;
   logic [31:0]   offset;

   always_comb begin
      // NOTE: every variable gets its hold/default value before any branch, so no path
      // leaves one unassigned and no latch is inferred.
      rx_s1_d = uart_rx_pin;  rx_s2_d = rx_s1_q;  rx_s3_d = rx_s2_q;
      rx_busy_d = rx_busy_q;  rx_cnt_d = rx_cnt_q;  rx_bit_d = rx_bit_q;
      rx_shift_d = rx_shift_q;  rx_data_d = rx_data_q;
      rx_valid_d = 1'b0;  rx_ferr_d = 1'b0;
      state_d = state_q;  byte_cnt_d = byte_cnt_q;  gap_d = gap_q;
      crc_d = crc_q;  exp_idx_d = exp_idx_q;  word_d = word_q;
      tx_busy_d = tx_busy_q;  tx_pin_d = tx_pin_q;  tx_cnt_d = tx_cnt_q;
      tx_left_d = tx_left_q;  tx_frame_d = tx_frame_q;
      mem_we_d = 1'b0;  mem_addr_d = mem_addr_q;  mem_wdata_d = mem_wdata_q;
      dl_done_d = dl_done_q;  file_size_d = file_size_q;
      buf_we = 1'b0;  buf_idx = byte_cnt_q;  tx_start = 1'b0;  tx_byte = ACK;
      wbase = {1'b0, word_q, 2'b00};
      offset = ({24'd0, exp_idx_q - 8'd1} << 5) + {27'd0, word_q, 2'b00};

      // Receiver: bit 0 is the start bit, 1..8 data (LSB first), 9 the stop bit.
      if (!rx_busy_q) begin
         if (rx_s3_q && !rx_s2_q) begin
            rx_busy_d = 1'b1;
            rx_cnt_d  = CW'(CLKS_PER_BIT / 2 - 1);
            rx_bit_d  = 4'd0;
         end
      end else if (rx_cnt_q != '0) begin
         rx_cnt_d = rx_cnt_q - 1'b1;
      end else begin
         rx_cnt_d = CW'(CLKS_PER_BIT - 1);
         rx_bit_d = rx_bit_q + 4'd1;
         if (rx_bit_q == 4'd9) begin
            rx_busy_d = 1'b0;
            rx_bit_d  = 4'd0;
            if (rx_s2_q) begin
               rx_valid_d = 1'b1;
               rx_data_d  = rx_shift_q;
            end else begin
               rx_ferr_d = 1'b1;
            end
         end else if (rx_bit_q != 4'd0) begin
            rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
         end
      end

      case (state_q)
         S_IDLE, S_RECV: begin
            if (state_q == S_RECV) begin
               if (rx_busy_q) begin
                  gap_d = '0;
               end else if (gap_q == GW'(GAP_TIMEOUT - 1)) begin
                  state_d = S_IDLE;  byte_cnt_d = '0;  gap_d = '0;
               end else begin
                  gap_d = gap_q + 1'b1;
               end
            end
            if (rx_ferr_q) begin
               state_d = S_IDLE;  byte_cnt_d = '0;  gap_d = '0;
            end else if (rx_valid_q) begin
               buf_we = 1'b1;
               gap_d  = '0;
               if (byte_cnt_q == 6'd0) crc_d = 16'hFFFF;
               else if (byte_cnt_q <= 6'd32) crc_d = crc16_byte(crc_q, rx_data_q);
               if (byte_cnt_q == 6'd34) begin
                  state_d = S_CHECK;  byte_cnt_d = '0;
               end else begin
                  state_d = S_RECV;  byte_cnt_d = byte_cnt_q + 6'd1;
               end
            end
         end
         S_CHECK: begin
            state_d = S_IDLE;
            if (crc_q == {pkt_mem[34], pkt_mem[33]} && pkt_mem[0] == exp_idx_q) begin
               if (exp_idx_q == 8'd0) begin
                  file_size_d = {pkt_mem[29], pkt_mem[30], pkt_mem[31], pkt_mem[32]};
                  if (file_size_d == 32'd0) dl_done_d = 1'b1;
                  exp_idx_d = exp_idx_q + 8'd1;
                  tx_start  = 1'b1;
               end else begin
                  state_d = S_WRITE;  word_d = 3'd0;
               end
            end else begin
               tx_start = 1'b1;  tx_byte = NACK;
            end
         end
         S_WRITE: begin
            if (!dl_done_q && offset < file_size_q) begin
               mem_we_d    = 1'b1;
               mem_addr_d  = BASE_ADDR + offset;
               mem_wdata_d = {pkt_mem[wbase + 6'd4], pkt_mem[wbase + 6'd3],
                              pkt_mem[wbase + 6'd2], pkt_mem[wbase + 6'd1]};
               if (offset + 32'd4 >= file_size_q) dl_done_d = 1'b1;
            end
            word_d = word_q + 3'd1;
            if (word_q == 3'd7) begin
               state_d   = S_IDLE;
               exp_idx_d = exp_idx_q + 8'd1;
               tx_start  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Transmitter: start bit goes out on the clock after the launch request.
      if (tx_start) begin
         tx_busy_d = 1'b1;  tx_pin_d = 1'b0;  tx_frame_d = {1'b1, tx_byte};
         tx_left_d = 4'd9;  tx_cnt_d = CW'(CLKS_PER_BIT - 1);
      end else if (tx_busy_q) begin
         if (tx_cnt_q != '0) begin
            tx_cnt_d = tx_cnt_q - 1'b1;
         end else if (tx_left_q == 4'd0) begin
            tx_busy_d = 1'b0;
         end else begin
            tx_pin_d   = tx_frame_q[0];
            tx_frame_d = {1'b1, tx_frame_q[8:1]};
            tx_left_d  = tx_left_q - 4'd1;
            tx_cnt_d   = CW'(CLKS_PER_BIT - 1);
         end
      end

      if (!dbg_en) begin
         state_d = S_IDLE;  byte_cnt_d = '0;  gap_d = '0;  buf_we = 1'b0;
         rx_busy_d = 1'b0;  rx_valid_d = 1'b0;  rx_ferr_d = 1'b0;
         tx_busy_d = 1'b0;  tx_pin_d = 1'b1;  mem_we_d = 1'b0;
      end
   end

   // NOTE: non-blocking assignments here so every flop updates from pre-edge values,
   // whatever order the statements are written in.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_s1_q <= 1'b1;  rx_s2_q <= 1'b1;  rx_s3_q <= 1'b1;
         rx_busy_q <= 1'b0;  rx_cnt_q <= '0;  rx_bit_q <= '0;
         rx_shift_q <= '0;  rx_data_q <= '0;  rx_valid_q <= 1'b0;  rx_ferr_q <= 1'b0;
         state_q <= S_IDLE;  byte_cnt_q <= '0;  gap_q <= '0;
         crc_q <= 16'hFFFF;  exp_idx_q <= '0;  word_q <= '0;
         tx_busy_q <= 1'b0;  tx_pin_q <= 1'b1;  tx_cnt_q <= '0;
         tx_left_q <= '0;  tx_frame_q <= '1;
         mem_we_q <= 1'b0;  mem_addr_q <= '0;  mem_wdata_q <= '0;
         dl_done_q <= 1'b0;  file_size_q <= '0;
      end else begin
         rx_s1_q <= rx_s1_d;  rx_s2_q <= rx_s2_d;  rx_s3_q <= rx_s3_d;
         rx_busy_q <= rx_busy_d;  rx_cnt_q <= rx_cnt_d;  rx_bit_q <= rx_bit_d;
         rx_shift_q <= rx_shift_d;  rx_data_q <= rx_data_d;
         rx_valid_q <= rx_valid_d;  rx_ferr_q <= rx_ferr_d;
         state_q <= state_d;  byte_cnt_q <= byte_cnt_d;  gap_q <= gap_d;
         crc_q <= crc_d;  exp_idx_q <= exp_idx_d;  word_q <= word_d;
         tx_busy_q <= tx_busy_d;  tx_pin_q <= tx_pin_d;  tx_cnt_q <= tx_cnt_d;
         tx_left_q <= tx_left_d;  tx_frame_q <= tx_frame_d;
         mem_we_q <= mem_we_d;  mem_addr_q <= mem_addr_d;  mem_wdata_q <= mem_wdata_d;
         dl_done_q <= dl_done_d;  file_size_q <= file_size_d;
      end
   end

   // NOTE: the packet buffer has no reset; every byte is rewritten by the current
   // packet before CHECK or WRITE reads it, so reset values would never be observed.
   always_ff @(posedge clk) begin
      if (buf_we) pkt_mem[buf_idx] <= rx_data_q;
   end

   assign uart_tx_pin = tx_pin_q;
   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign dl_done     = dl_done_q;
   assign file_size   = file_size_q;
   assign cpu_hold    = dbg_en & ~dl_done_q;
endmodule

// File: tb/tb_uart_dbg_loader.sv
// Self-checking bench for uart_dbg_loader: bit-banged host packets, a UART reply monitor,
// a memory-write monitor and a packet-level reference model of the download protocol.
module tb_uart_dbg_loader;
   localparam int          CPB  = 8;
   localparam logic [31:0] BASE = 32'h0;
   localparam int          GAP  = 1024;

   logic        clk = 1'b0;
   logic        rst, dbg_en, uart_rx_pin;
   logic        uart_tx_pin, mem_we, cpu_hold, dl_done;
   logic [31:0] mem_addr, mem_wdata, file_size;

   uart_dbg_loader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(BASE), .GAP_TIMEOUT(GAP)) dut (
      .clk(clk), .rst(rst), .dbg_en(dbg_en), .uart_rx_pin(uart_rx_pin),
      .uart_tx_pin(uart_tx_pin), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .dl_done(dl_done), .file_size(file_size)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  pkt [35];
   logic [7:0]  tx_q [$];
   logic [31:0] wa_q [$], wd_q [$];
   logic [31:0] ea_q [$], ed_q [$];
   logic [7:0]  m_idx, m_reply;
   logic [31:0] m_fs;
   logic        m_done;

   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         wa_q.push_back(mem_addr);
         wd_q.push_back(mem_wdata);
      end
   end

   // Reply monitor: decodes 8N1 frames on uart_tx_pin; a bad stop bit is queued as 8'hEE.
   initial begin : tx_mon
      logic       prev;
      logic [7:0] b;
      prev = 1'b1;
      forever begin
         @(negedge clk);
         if (prev === 1'b1 && uart_tx_pin === 1'b0) begin
            repeat (CPB / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clk);
               b[i] = uart_tx_pin;
            end
            repeat (CPB) @(negedge clk);
            tx_q.push_back(uart_tx_pin === 1'b1 ? b : 8'hEE);
         end
         prev = uart_tx_pin;
      end
   end

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1);
   end

   function automatic logic [31:0] bswap(input logic [31:0] x);
      return {x[7:0], x[15:8], x[23:16], x[31:24]};
   endfunction

   function automatic logic [15:0] ref_crc();
      logic [15:0] c = 16'hFFFF;
      for (int k = 1; k <= 32; k++) begin
         c = c ^ {8'h00, pkt[k]};
         for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
      end
      return c;
   endfunction

   // payload[32*i +: 32] is word i; its low byte is packet byte 4i+1.
   task automatic make_pkt(input logic [7:0] idx, input logic [255:0] payload);
      logic [15:0] c;
      pkt[0] = idx;
      for (int k = 0; k < 32; k++) pkt[k + 1] = payload[8 * k +: 8];
      c = ref_crc();
      pkt[33] = c[7:0];
      pkt[34] = c[15:8];
   endtask

   task automatic model_reset();
      m_idx = 8'd0;  m_fs = 32'd0;  m_done = 1'b0;
   endtask

   // Predicts reply byte and memory writes for the packet currently in pkt[].
   task automatic model_pkt();
      logic [31:0] off;
      ea_q.delete();
      ed_q.delete();
      if (ref_crc() == {pkt[34], pkt[33]} && pkt[0] == m_idx) begin
         m_reply = 8'h06;
         if (m_idx == 8'd0) begin
            m_fs = {pkt[29], pkt[30], pkt[31], pkt[32]};
            if (m_fs == 32'd0) m_done = 1'b1;
         end else begin
            for (int i = 0; i < 8; i++) begin
               off = (32'(m_idx) - 32'd1) * 32'd32 + 32'(4 * i);
               if (!m_done && off < m_fs) begin
                  ea_q.push_back(BASE + off);
                  ed_q.push_back({pkt[4*i+4], pkt[4*i+3], pkt[4*i+2], pkt[4*i+1]});
                  if (off + 32'd4 >= m_fs) m_done = 1'b1;
               end
            end
         end
         m_idx = m_idx + 8'd1;
      end else begin
         m_reply = 8'h15;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      logic [9:0] f;
      f = {1'b1, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         uart_rx_pin = f[i];
         repeat (CPB - 1) @(negedge clk);
      end
   endtask

   task automatic send_pkt(input int n);
      for (int k = 0; k < n; k++) send_byte(pkt[k]);
   endtask

   task automatic xfer(output logic got, output logic [7:0] reply);
      tx_q.delete();  wa_q.delete();  wd_q.delete();
      send_pkt(35);
      got = 1'b0;
      reply = 8'h00;
      for (int t = 0; t < 400 && !got; t++) begin
         @(negedge clk);
         if (tx_q.size() > 0) begin
            got = 1'b1;
            reply = tx_q.pop_front();
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;  dbg_en = 1'b0;  uart_rx_pin = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++; if (uart_tx_pin !== 1'b1) begin errors++; $display("FAIL reset_tx actual=%b required=1", uart_tx_pin); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_we actual=%b required=0", mem_we); end
      checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem addr=%h data=%h required=0", mem_addr, mem_wdata); end
      checks++; if (dl_done !== 1'b0 || file_size !== 32'h0) begin errors++; $display("FAIL reset_dl done=%b size=%h required=0", dl_done, file_size); end
      checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL reset_hold_off actual=%b required=0", cpu_hold); end
      dbg_en = 1'b1;
      @(negedge clk);
      checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL reset_hold_on actual=%b required=1", cpu_hold); end
      model_reset();
   endtask

   task automatic test_pkt0(input logic [31:0] fs, input string tag);
      logic got; logic [7:0] r;
      make_pkt(8'd0, {bswap(fs), 224'h0});
      model_pkt();
      xfer(got, r);
      checks++; if (!got || r !== 8'h06) begin errors++; $display("FAIL %s_reply got=%b actual=%h required=06", tag, got, r); end
      checks++; if (file_size !== fs) begin errors++; $display("FAIL %s_size actual=%h required=%h", tag, file_size, fs); end
      checks++; if (wa_q.size() != 0) begin errors++; $display("FAIL %s_nowrite actual=%0d required=0", tag, wa_q.size()); end
   endtask

   task automatic test_bad_idx();
      logic got; logic [7:0] r;
      make_pkt(8'd3, {8{$urandom}});
      model_pkt();
      xfer(got, r);
      checks++; if (!got || r !== 8'h15) begin errors++; $display("FAIL bad_idx_reply got=%b actual=%h required=15", got, r); end
      checks++; if (wa_q.size() != 0) begin errors++; $display("FAIL bad_idx_nowrite actual=%0d required=0", wa_q.size()); end
   endtask

   task automatic test_pkt1();
      logic got; logic [7:0] r;
      make_pkt(8'd1, {32'h4B5A6978, 32'h0F1E2D3C, 32'h89ABCDEF, 32'h01234567,
                      32'hDDEEFF00, 32'h99AABBCC, 32'h55667788, 32'h11223344});
      model_pkt();
      xfer(got, r);
      checks++; if (!got || r !== 8'h06) begin errors++; $display("FAIL pkt1_reply got=%b actual=%h required=06", got, r); end
      checks++; if (wa_q.size() != 8) begin errors++; $display("FAIL pkt1_count actual=%0d required=8", wa_q.size()); end
      else begin
         checks++; if (wa_q[0] !== 32'h0 || wd_q[0] !== 32'h11223344) begin errors++; $display("FAIL pkt1_first addr=%h data=%h required 0/11223344", wa_q[0], wd_q[0]); end
         checks++; if (wa_q[7] !== 32'h1C) begin errors++; $display("FAIL pkt1_last addr=%h required=1c", wa_q[7]); end
      end
      for (int i = 0; i < ea_q.size() && i < wa_q.size(); i++) begin
         checks++; if (wa_q[i] !== ea_q[i] || wd_q[i] !== ed_q[i]) begin errors++; $display("FAIL pkt1_word%0d actual=%h:%h required=%h:%h", i, wa_q[i], wd_q[i], ea_q[i], ed_q[i]); end
      end
      checks++; if (dl_done !== 1'b0 || cpu_hold !== 1'b1) begin errors++; $display("FAIL pkt1_done done=%b hold=%b required 0/1", dl_done, cpu_hold); end
   endtask

   task automatic test_crc_nack_resend();
      logic got; logic [7:0] r;
      make_pkt(8'd2, {8{$urandom}});
      pkt[33] = ~pkt[33];
      model_pkt();
      xfer(got, r);
      checks++; if (!got || r !== 8'h15) begin errors++; $display("FAIL crc_bad_reply got=%b actual=%h required=15", got, r); end
      checks++; if (wa_q.size() != 0) begin errors++; $display("FAIL crc_bad_nowrite actual=%0d required=0", wa_q.size()); end
      pkt[33] = ~pkt[33];
      model_pkt();
      xfer(got, r);
      checks++; if (!got || r !== 8'h06) begin errors++; $display("FAIL resend_reply got=%b actual=%h required=06", got, r); end
      checks++; if (wa_q.size() != 8) begin errors++; $display("FAIL resend_count actual=%0d required=8", wa_q.size()); end
      else begin
         checks++; if (wa_q[0] !== 32'h20 || wa_q[7] !== 32'h3C) begin errors++; $display("FAIL resend_range first=%h last=%h required 20/3c", wa_q[0], wa_q[7]); end
      end
      for (int i = 0; i < ea_q.size() && i < wa_q.size(); i++) begin
         checks++; if (wa_q[i] !== ea_q[i] || wd_q[i] !== ed_q[i]) begin errors++; $display("FAIL resend_word%0d actual=%h:%h required=%h:%h", i, wa_q[i], wd_q[i], ea_q[i], ed_q[i]); end
      end
      checks++; if (dl_done !== 1'b1 || cpu_hold !== 1'b0) begin errors++; $display("FAIL resend_done done=%b hold=%b required 1/0", dl_done, cpu_hold); end
   endtask

   task automatic test_after_done();
      logic got; logic [7:0] r;
      make_pkt(8'd3, {8{$urandom}});
      model_pkt();
      xfer(got, r);
      checks++; if (!got || r !== 8'h06) begin errors++; $display("FAIL after_done_reply got=%b actual=%h required=06", got, r); end
      checks++; if (wa_q.size() != 0) begin errors++; $display("FAIL after_done_nowrite actual=%0d required=0", wa_q.size()); end
      checks++; if (dl_done !== 1'b1) begin errors++; $display("FAIL after_done_sticky actual=%b required=1", dl_done); end
   endtask

   task automatic test_gap_timeout();
      do_reset();
      model_reset();
      tx_q.delete();
      make_pkt(8'd0, {bswap(32'h24), 224'h0});
      send_pkt(17);
      repeat (GAP + 200) @(negedge clk);
      checks++; if (tx_q.size() != 0) begin errors++; $display("FAIL gap_noreply actual=%0d replies required=0", tx_q.size()); end
      test_pkt0(32'h24, "gap_pkt0");
   endtask

   task automatic test_partial_size();
      logic got; logic [7:0] r;
      make_pkt(8'd1, {8{$urandom}});
      model_pkt();
      xfer(got, r);
      checks++; if (!got || r !== 8'h06 || wa_q.size() != 8) begin errors++; $display("FAIL part_pkt1 reply=%h writes=%0d required 06/8", r, wa_q.size()); end
      checks++; if (dl_done !== 1'b0) begin errors++; $display("FAIL part_pkt1_done actual=%b required=0", dl_done); end
      make_pkt(8'd2, {8{$urandom}});
      model_pkt();
      xfer(got, r);
      checks++; if (!got || r !== 8'h06) begin errors++; $display("FAIL part_pkt2_reply got=%b actual=%h required=06", got, r); end
      checks++; if (wa_q.size() != 1) begin errors++; $display("FAIL part_pkt2_count actual=%0d required=1", wa_q.size()); end
      else begin
         checks++; if (wa_q[0] !== 32'h20 || wd_q[0] !== ed_q[0]) begin errors++; $display("FAIL part_pkt2_word actual=%h:%h required=20:%h", wa_q[0], wd_q[0], ed_q[0]); end
      end
      checks++; if (dl_done !== 1'b1) begin errors++; $display("FAIL part_pkt2_done actual=%b required=1", dl_done); end
   endtask

   task automatic test_random();
      logic got; logic [7:0] r; logic [255:0] pay; logic [31:0] fs; int kind;
      do_reset();
      model_reset();
      fs = 32'($urandom_range(1, 80));
      for (int n = 0; n < 6 && !m_done; n++) begin
         for (int i = 0; i < 8; i++) pay[32*i +: 32] = $urandom;
         if (m_idx == 8'd0) pay[255:224] = bswap(fs);
         kind = int'($urandom_range(0, 3));
         make_pkt(kind == 1 ? m_idx + 8'd1 : m_idx, pay);
         if (kind == 0) pkt[34] = pkt[34] ^ 8'h04;
         model_pkt();
         xfer(got, r);
         checks++; if (!got || r !== m_reply) begin errors++; $display("FAIL rand%0d_reply got=%b actual=%h required=%h", n, got, r, m_reply); end
         checks++; if (wa_q.size() != ea_q.size()) begin errors++; $display("FAIL rand%0d_count actual=%0d required=%0d", n, wa_q.size(), ea_q.size()); end
         for (int i = 0; i < ea_q.size() && i < wa_q.size(); i++) begin
            checks++; if (wa_q[i] !== ea_q[i] || wd_q[i] !== ed_q[i]) begin errors++; $display("FAIL rand%0d_word%0d actual=%h:%h required=%h:%h", n, i, wa_q[i], wd_q[i], ea_q[i], ed_q[i]); end
         end
         checks++; if (dl_done !== m_done || file_size !== m_fs) begin errors++; $display("FAIL rand%0d_state done=%b size=%h required=%b/%h", n, dl_done, file_size, m_done, m_fs); end
      end
   endtask

   task automatic test_rst_mid_packet();
      make_pkt(8'd5, {8{$urandom}});
      send_pkt(20);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      tx_q.delete();  wa_q.delete();
      @(negedge clk);
      checks++; if (file_size !== 32'h0 || dl_done !== 1'b0) begin errors++; $display("FAIL rst_mid_dl size=%h done=%b required 0/0", file_size, dl_done); end
      checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_we !== 1'b0) begin errors++; $display("FAIL rst_mid_mem addr=%h data=%h we=%b required 0", mem_addr, mem_wdata, mem_we); end
      checks++; if (uart_tx_pin !== 1'b1 || cpu_hold !== 1'b1) begin errors++; $display("FAIL rst_mid_pins tx=%b hold=%b required 1/1", uart_tx_pin, cpu_hold); end
      repeat (GAP + 200) @(negedge clk);
      checks++; if (tx_q.size() != 0 || wa_q.size() != 0) begin errors++; $display("FAIL rst_mid_quiet replies=%0d writes=%0d required 0/0", tx_q.size(), wa_q.size()); end
      model_reset();
      test_pkt0(32'h10, "rst_pkt0");
   endtask

   initial begin
      test_reset();
      test_pkt0(32'h40, "pkt0");
      test_bad_idx();
      test_pkt1();
      test_crc_nack_resend();
      test_after_done();
      test_gap_timeout();
      test_partial_size();
      test_random();
      test_rst_mid_packet();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
